// File: rtl/block_expander.sv
// Block expander: walks a retired-instruction block with per-address size lookups and
// emits one record per instruction, flagging blocks whose sizes do not add up.
package mure_pkg;
    parameter int unsigned XLEN        = 64;
    parameter int unsigned IRETIRE_LEN = 32;
    parameter int unsigned ITYPE_LEN   = 3;
    parameter int unsigned CAUSE_LEN   = 5;
    parameter int unsigned PRIV_LEN    = 2;
endpackage

module block_expander #(
    parameter int unsigned XLEN        = mure_pkg::XLEN,
    parameter int unsigned IRETIRE_LEN = mure_pkg::IRETIRE_LEN,
    parameter int unsigned ITYPE_LEN   = mure_pkg::ITYPE_LEN,
    parameter int unsigned CAUSE_LEN   = mure_pkg::CAUSE_LEN,
    parameter int unsigned PRIV_LEN    = mure_pkg::PRIV_LEN
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,

    input  logic                   blk_valid_i,
    output logic                   blk_ready_o,
    input  logic [IRETIRE_LEN-1:0] blk_iretire_i,
    input  logic                   blk_ilastsize_i,
    input  logic [ITYPE_LEN-1:0]   blk_itype_i,
    input  logic [CAUSE_LEN-1:0]   blk_cause_i,
    input  logic [XLEN-1:0]        blk_tval_i,
    input  logic [PRIV_LEN-1:0]    blk_priv_i,
    input  logic [XLEN-1:0]        blk_iaddr_i,

    output logic                   imem_req_o,
    output logic [XLEN-1:0]        imem_addr_o,
    input  logic                   imem_rsp_valid_i,
    input  logic                   imem_rsp_compressed_i,

    output logic                   instr_valid_o,
    input  logic                   instr_ready_i,
    output logic [XLEN-1:0]        instr_pc_o,
    output logic                   instr_compressed_o,
    output logic                   instr_retired_o,
    output logic                   instr_last_o,
    output logic [ITYPE_LEN-1:0]   instr_itype_o,
    output logic [CAUSE_LEN-1:0]   instr_cause_o,
    output logic [XLEN-1:0]        instr_tval_o,
    output logic [PRIV_LEN-1:0]    instr_priv_o,

    output logic                   err_o
);

    typedef enum logic [1:0] {StIdle, StFetch, StEmit} state_e;

    state_e                 state_q, state_d;
    logic [XLEN-1:0]        pc_q, pc_d;
    logic [IRETIRE_LEN-1:0] rem_q, rem_d;
    logic                   ilastsize_q, ilastsize_d;
    logic [ITYPE_LEN-1:0]   itype_q, itype_d;
    logic [CAUSE_LEN-1:0]   cause_q, cause_d;
    logic [XLEN-1:0]        tval_q, tval_d;
    logic [PRIV_LEN-1:0]    priv_q, priv_d;

    logic [XLEN-1:0]        rec_pc_q, rec_pc_d;
    logic                   rec_compressed_q, rec_compressed_d;
    logic                   rec_retired_q, rec_retired_d;
    logic                   rec_last_q, rec_last_d;
    logic [ITYPE_LEN-1:0]   rec_itype_q, rec_itype_d;
    logic [CAUSE_LEN-1:0]   rec_cause_q, rec_cause_d;
    logic [XLEN-1:0]        rec_tval_q, rec_tval_d;

    logic [IRETIRE_LEN-1:0] rsp_size;
    logic [IRETIRE_LEN-1:0] last_size;
    logic [IRETIRE_LEN-1:0] rec_size;
    logic                   rsp_last;
    logic                   blk_side;
    logic                   lat_side;

    // Cause/tval only carry meaning for exceptions (1) and interrupts (2).
    assign blk_side = (blk_itype_i == ITYPE_LEN'(1)) || (blk_itype_i == ITYPE_LEN'(2));
    assign lat_side = (itype_q == ITYPE_LEN'(1)) || (itype_q == ITYPE_LEN'(2));

    assign rsp_size  = imem_rsp_compressed_i ? IRETIRE_LEN'(1) : IRETIRE_LEN'(2);
    assign last_size = ilastsize_q ? IRETIRE_LEN'(2) : IRETIRE_LEN'(1);
    assign rec_size  = rec_compressed_q ? IRETIRE_LEN'(1) : IRETIRE_LEN'(2);
    assign rsp_last  = (rem_q == rsp_size);

    always_comb begin
        state_d          = state_q;
        pc_d             = pc_q;
        rem_d            = rem_q;
        ilastsize_d      = ilastsize_q;
        itype_d          = itype_q;
        cause_d          = cause_q;
        tval_d           = tval_q;
        priv_d           = priv_q;
        rec_pc_d         = rec_pc_q;
        rec_compressed_d = rec_compressed_q;
        rec_retired_d    = rec_retired_q;
        rec_last_d       = rec_last_q;
        rec_itype_d      = rec_itype_q;
        rec_cause_d      = rec_cause_q;
        rec_tval_d       = rec_tval_q;
        err_o            = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (blk_valid_i) begin
                    pc_d        = blk_iaddr_i;
                    rem_d       = blk_iretire_i;
                    ilastsize_d = blk_ilastsize_i;
                    itype_d     = blk_itype_i;
                    cause_d     = blk_cause_i;
                    tval_d      = blk_tval_i;
                    priv_d      = blk_priv_i;
                    if (blk_iretire_i != '0) begin
                        state_d = StFetch;
                    end else begin
                        // Nothing retired: a single trap-only record, no lookup needed.
                        rec_pc_d         = blk_iaddr_i;
                        rec_compressed_d = 1'b0;
                        rec_retired_d    = 1'b0;
                        rec_last_d       = 1'b1;
                        rec_itype_d      = blk_itype_i;
                        rec_cause_d      = blk_side ? blk_cause_i : '0;
                        rec_tval_d       = blk_side ? blk_tval_i : '0;
                        state_d          = StEmit;
                    end
                end
            end
            StFetch: begin
                if (imem_rsp_valid_i) begin
                    if ((rsp_size > rem_q) || (rsp_last && (rsp_size != last_size))) begin
                        err_o   = 1'b1;
                        state_d = StIdle;
                    end else begin
                        rec_pc_d         = pc_q;
                        rec_compressed_d = imem_rsp_compressed_i;
                        rec_retired_d    = 1'b1;
                        rec_last_d       = rsp_last;
                        rec_itype_d      = rsp_last ? itype_q : '0;
                        rec_cause_d      = (rsp_last && lat_side) ? cause_q : '0;
                        rec_tval_d       = (rsp_last && lat_side) ? tval_q : '0;
                        state_d          = StEmit;
                    end
                end
            end
            StEmit: begin
                if (instr_ready_i) begin
                    if (rec_last_q) begin
                        state_d = StIdle;
                    end else begin
                        pc_d    = pc_q + (rec_compressed_q ? XLEN'(2) : XLEN'(4));
                        rem_d   = rem_q - rec_size;
                        state_d = StFetch;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q          <= StIdle;
            pc_q             <= '0;
            rem_q            <= '0;
            ilastsize_q      <= 1'b0;
            itype_q          <= '0;
            cause_q          <= '0;
            tval_q           <= '0;
            priv_q           <= '0;
            rec_pc_q         <= '0;
            rec_compressed_q <= 1'b0;
            rec_retired_q    <= 1'b0;
            rec_last_q       <= 1'b0;
            rec_itype_q      <= '0;
            rec_cause_q      <= '0;
            rec_tval_q       <= '0;
        end else begin
            state_q          <= state_d;
            pc_q             <= pc_d;
            rem_q            <= rem_d;
            ilastsize_q      <= ilastsize_d;
            itype_q          <= itype_d;
            cause_q          <= cause_d;
            tval_q           <= tval_d;
            priv_q           <= priv_d;
            rec_pc_q         <= rec_pc_d;
            rec_compressed_q <= rec_compressed_d;
            rec_retired_q    <= rec_retired_d;
            rec_last_q       <= rec_last_d;
            rec_itype_q      <= rec_itype_d;
            rec_cause_q      <= rec_cause_d;
            rec_tval_q       <= rec_tval_d;
        end
    end

    always_comb begin
        blk_ready_o        = (state_q == StIdle);
        imem_req_o         = (state_q == StFetch);
        imem_addr_o        = (state_q == StFetch) ? pc_q : '0;
        instr_valid_o      = (state_q == StEmit);
        instr_pc_o         = rec_pc_q;
        instr_compressed_o = rec_compressed_q;
        instr_retired_o    = rec_retired_q;
        instr_last_o       = rec_last_q;
        instr_itype_o      = rec_itype_q;
        instr_cause_o      = rec_cause_q;
        instr_tval_o       = rec_tval_q;
        instr_priv_o       = priv_q;
    end

endmodule
